// File: rtl/led_blink_multi_if.sv
// Control/status bundle for the N-channel LED blinker: per-channel levels in,
// registered LED drive and burst-done flags out, plus per-channel FSM state.
interface led_blink_multi_if #(
  parameter int N_CH = 4
);
  // No valid/ready pair: every input is a level the blinker samples on each
  // rising clk edge, and every output is a registered level valid at all times.
  logic [N_CH-1:0]   i_en;
  logic [2*N_CH-1:0] i_sel;
  logic [N_CH-1:0]   i_burst;
  logic [N_CH-1:0]   i_start;
  logic [N_CH-1:0]   o_led;
  logic [N_CH-1:0]   o_done;
  logic [3*N_CH-1:0] dbg_state;

  modport master (
    output i_en, i_sel, i_burst, i_start,
    input  o_led, o_done, dbg_state
  );

  modport slave (
    input  i_en, i_sel, i_burst, i_start,
    output o_led, o_done, dbg_state
  );
endinterface

// File: rtl/led_blink_multi.sv
// N independent LED channels, each with four divided blink rates and either
// continuous blinking or a triggered burst of BURST_LEN pulses with a done flag.
module led_blink_multi #(
  parameter int N_CH      = 4,
  parameter int CLK_HZ    = 25_000_000,
  parameter int RATE0_HZ  = 100,
  parameter int RATE1_HZ  = 50,
  parameter int RATE2_HZ  = 10,
  parameter int RATE3_HZ  = 1,
  parameter int BURST_LEN = 3
) (
  input logic              clk,
  input logic              rst,
  led_blink_multi_if.slave bus
);

  localparam int HALF0 = CLK_HZ / (2 * RATE0_HZ);
  localparam int HALF1 = CLK_HZ / (2 * RATE1_HZ);
  localparam int HALF2 = CLK_HZ / (2 * RATE2_HZ);
  localparam int HALF3 = CLK_HZ / (2 * RATE3_HZ);
  localparam int HALF01 = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int HALF23 = (HALF2 > HALF3) ? HALF2 : HALF3;
  localparam int HALF_MAX = (HALF01 > HALF23) ? HALF01 : HALF23;
  localparam int CW = $clog2(HALF_MAX) + 1;
  localparam int PW = $clog2(BURST_LEN + 1);

  localparam logic [CW-1:0] H0M1 = CW'(HALF0 - 1);
  localparam logic [CW-1:0] H1M1 = CW'(HALF1 - 1);
  localparam logic [CW-1:0] H2M1 = CW'(HALF2 - 1);
  localparam logic [CW-1:0] H3M1 = CW'(HALF3 - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(BURST_LEN - 1);

  if (HALF0 < 1 || HALF1 < 1 || HALF2 < 1 || HALF3 < 1) begin : g_bad_half
    $error("led_blink_multi: a blink rate is too fast for CLK_HZ (half period < 1)");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("led_blink_multi: BURST_LEN must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_BLINK = 3'd1,
    ST_ARMED = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  logic [N_CH-1:0]   led_vec;
  logic [N_CH-1:0]   done_vec;
  logic [3*N_CH-1:0] state_vec;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pcnt;
    logic [1:0]    sel_q;
    logic          burst_q;
    logic          led;
    logic          done;
    logic [CW-1:0] half_m1;
    logic          at_top;
    logic          en;
    logic          burst_in;
    logic          start;
    logic [1:0]    sel_in;

    assign en       = bus.i_en[ch];
    assign burst_in = bus.i_burst[ch];
    assign start    = bus.i_start[ch];
    assign sel_in   = bus.i_sel[2*ch +: 2];

    always_comb begin
      half_m1 = H0M1;
      case (sel_q)
        2'd0:    half_m1 = H0M1;
        2'd1:    half_m1 = H1M1;
        2'd2:    half_m1 = H2M1;
        default: half_m1 = H3M1;
      endcase
    end

    assign at_top = (cnt == half_m1);

    // Priority: reset, enable low, mode change, rate change, then state action.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= ST_OFF;
        cnt     <= '0;
        pcnt    <= '0;
        sel_q   <= '0;
        burst_q <= 1'b0;
        led     <= 1'b0;
        done    <= 1'b0;
      end else if (state == ST_OFF) begin
        led  <= 1'b0;
        done <= 1'b0;
        cnt  <= '0;
        pcnt <= '0;
        if (en) begin
          state   <= burst_in ? ST_ARMED : ST_BLINK;
          sel_q   <= sel_in;
          burst_q <= burst_in;
        end
      end else if (!en) begin
        state <= ST_OFF;
        led   <= 1'b0;
        done  <= 1'b0;
        cnt   <= '0;
        pcnt  <= '0;
      end else if (burst_in != burst_q) begin
        state   <= burst_in ? ST_ARMED : ST_BLINK;
        burst_q <= burst_in;
        led     <= 1'b0;
        done    <= 1'b0;
        cnt     <= '0;
        pcnt    <= '0;
      end else if (sel_in != sel_q) begin
        // The LED keeps its level; the new half period counts from zero.
        sel_q <= sel_in;
        cnt   <= '0;
      end else begin
        case (state)
          ST_BLINK: begin
            if (at_top) begin
              led <= ~led;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ARMED: begin
            led <= 1'b0;
            cnt <= '0;
            if (start) begin
              state <= ST_BURST;
              done  <= 1'b0;
              pcnt  <= '0;
            end
          end
          ST_BURST: begin
            if (at_top) begin
              cnt <= '0;
              if (led) begin
                led  <= 1'b0;
                pcnt <= pcnt + 1'b1;
                if (pcnt == LAST_PULSE) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end else begin
                led <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DONE: begin
            led  <= 1'b0;
            done <= 1'b1;
            if (start) begin
              state <= ST_BURST;
              done  <= 1'b0;
              cnt   <= '0;
              pcnt  <= '0;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end

    assign led_vec[ch]           = led;
    assign done_vec[ch]          = done;
    assign state_vec[3*ch +: 3]  = state;
  end

  assign bus.o_led     = led_vec;
  assign bus.o_done    = done_vec;
  assign bus.dbg_state = state_vec;

endmodule

// File: tb/tb_led_blink_multi.sv
// Bench for led_blink_multi at CLK_HZ=2000 (half periods 10/20/100/1000 clks):
// expected output transitions are queued per scenario and matched as they occur.
module tb_led_blink_multi;
  localparam int N_CH = 4;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_blink_multi_if #(.N_CH(N_CH)) bus();

  led_blink_multi #(
    .N_CH      (N_CH),
    .CLK_HZ    (2000),
    .BURST_LEN (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [N_CH-1:0] mon_mask = '0;
  logic [N_CH-1:0] prev_led = '0;
  logic [N_CH-1:0] prev_done = '0;

  // Event word: channel, kind (0 = led, 1 = done), new value, edge number.
  function automatic logic [W-1:0] ev(int ch, bit kind, bit val, int t);
    return {2'(ch), kind, val, 28'(t)};
  endfunction

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [W-1:0] got;
    logic [W-1:0] want;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < 2; k++) begin
          logic cur;
          logic prv;
          cur = (k == 0) ? bus.o_led[c] : bus.o_done[c];
          prv = (k == 0) ? prev_led[c] : prev_done[c];
          if (mon_mask[c] && (cur !== prv)) begin
            got = ev(c, k[0], cur, cyc);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL event: got ch%0d %s=%0b at edge %0d, required no change",
                       got[31:30], got[29] ? "done" : "led", got[28], got[27:0]);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                errors++;
                $display("FAIL event: got ch%0d %s=%0b at edge %0d, required ch%0d %s=%0b at edge %0d",
                         got[31:30], got[29] ? "done" : "led", got[28], got[27:0],
                         want[31:30], want[29] ? "done" : "led", want[28], want[27:0]);
              end
            end
          end
        end
      end
      prev_led  = bus.o_led;
      prev_done = bus.o_done;
    end
  endtask

  task automatic quiesce();
    mon_mask    = '0;
    rst         = 1'b0;
    bus.i_en    = '0;
    bus.i_start = '0;
    wait_neg(3);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.i_en    = 4'hF;
    bus.i_sel   = 8'b11_10_01_00;
    bus.i_burst = '0;
    bus.i_start = '0;
    for (int i = 0; i < 5; i++) begin
      wait_neg(1);
      checks++;
      if (bus.o_led !== 4'h0 || bus.o_done !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold: led=%b done=%b, required led=0000 done=0000",
                 bus.o_led, bus.o_done);
      end
    end
  endtask

  task automatic test_rates();
    int start;
    int half[4];
    half = '{10, 20, 100, 1000};
    rst      = 1'b0;
    mon_mask = 4'hF;
    start    = cyc + 1;
    for (int t = start + 1; t <= start + 2000; t++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ((t - start) % half[c] == 0)
          exp_q.push_back(ev(c, 1'b0, (((t - start) / half[c]) % 2) == 1, t));
      end
    end
    wait_neg(start + 2005 - cyc);
    mon_mask = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rates_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_rate_change();
    int e;
    quiesce();
    bus.i_sel[1:0] = 2'd0;
    bus.i_burst[0] = 1'b0;
    bus.i_en       = 4'b0001;
    mon_mask       = 4'b0001;
    e = cyc + 1;
    exp_q.push_back(ev(0, 1'b0, 1'b1, e + 26));
    exp_q.push_back(ev(0, 1'b0, 1'b0, e + 46));
    exp_q.push_back(ev(0, 1'b0, 1'b1, e + 66));
    wait_neg(e + 5 - cyc);
    bus.i_sel[1:0] = 2'd1;
    wait_neg(e + 70 - cyc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rate_change_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_burst();
    int s;
    int t;
    quiesce();
    bus.i_sel[3:2] = 2'd0;
    bus.i_burst[1] = 1'b1;
    bus.i_en       = 4'b0010;
    mon_mask       = 4'b0010;
    wait_neg(3);
    bus.i_start[1] = 1'b1;
    s = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(ev(1, 1'b0, 1'b1, s + 10 + 20 * p));
      exp_q.push_back(ev(1, 1'b0, 1'b0, s + 20 + 20 * p));
    end
    exp_q.push_back(ev(1, 1'b1, 1'b1, s + 60));
    wait_neg(1);
    bus.i_start[1] = 1'b0;
    wait_neg(s + 24 - cyc);
    bus.i_start[1] = 1'b1;
    wait_neg(1);
    bus.i_start[1] = 1'b0;
    wait_neg(s + 70 - cyc);
    checks++;
    if (bus.o_done[1] !== 1'b1 || bus.o_led[1] !== 1'b0) begin
      errors++;
      $display("FAIL burst_done_hold: led=%b done=%b, required led=0 done=1",
               bus.o_led[1], bus.o_done[1]);
    end
    bus.i_start[1] = 1'b1;
    t = cyc + 1;
    exp_q.push_back(ev(1, 1'b1, 1'b0, t));
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(ev(1, 1'b0, 1'b1, t + 10 + 20 * p));
      exp_q.push_back(ev(1, 1'b0, 1'b0, t + 20 + 20 * p));
    end
    exp_q.push_back(ev(1, 1'b1, 1'b1, t + 60));
    wait_neg(1);
    bus.i_start[1] = 1'b0;
    wait_neg(t + 70 - cyc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_burst_abort();
    int u;
    int w;
    bus.i_start[1] = 1'b1;
    u = cyc + 1;
    exp_q.push_back(ev(1, 1'b1, 1'b0, u));
    exp_q.push_back(ev(1, 1'b0, 1'b1, u + 10));
    exp_q.push_back(ev(1, 1'b0, 1'b0, u + 15));
    wait_neg(1);
    bus.i_start[1] = 1'b0;
    wait_neg(u + 14 - cyc);
    bus.i_en[1] = 1'b0;
    wait_neg(1);
    checks++;
    if (bus.o_led[1] !== 1'b0 || bus.o_done[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: led=%b done=%b, required led=0 done=0",
               bus.o_led[1], bus.o_done[1]);
    end
    bus.i_en[1] = 1'b1;
    wait_neg(2);
    bus.i_start[1] = 1'b1;
    w = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(ev(1, 1'b0, 1'b1, w + 10 + 20 * p));
      exp_q.push_back(ev(1, 1'b0, 1'b0, w + 20 + 20 * p));
    end
    exp_q.push_back(ev(1, 1'b1, 1'b1, w + 60));
    wait_neg(1);
    bus.i_start[1] = 1'b0;
    wait_neg(w + 70 - cyc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_mode_change();
    int e;
    int s;
    quiesce();
    bus.i_sel[1:0] = 2'd0;
    bus.i_burst[0] = 1'b0;
    bus.i_en       = 4'b0001;
    mon_mask       = 4'b0001;
    e = cyc + 1;
    exp_q.push_back(ev(0, 1'b0, 1'b1, e + 10));
    exp_q.push_back(ev(0, 1'b0, 1'b0, e + 13));
    wait_neg(e + 12 - cyc);
    bus.i_burst[0] = 1'b1;
    bus.i_start[0] = 1'b1;
    wait_neg(1);
    bus.i_start[0] = 1'b0;
    wait_neg(20);
    checks++;
    if (bus.o_led[0] !== 1'b0 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_armed: led=%b done=%b, required led=0 done=0",
               bus.o_led[0], bus.o_done[0]);
    end
    bus.i_start[0] = 1'b1;
    s = cyc + 1;
    exp_q.push_back(ev(0, 1'b0, 1'b1, s + 10));
    exp_q.push_back(ev(0, 1'b0, 1'b0, s + 20));
    wait_neg(1);
    bus.i_start[0] = 1'b0;
    wait_neg(s + 22 - cyc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mode_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int r;
    quiesce();
    bus.i_sel   = 8'b11_10_01_00;
    bus.i_burst = '0;
    bus.i_en    = 4'hF;
    mon_mask    = 4'hF;
    e = cyc + 1;
    r = e + 37;
    exp_q.push_back(ev(0, 1'b0, 1'b1, e + 10));
    exp_q.push_back(ev(0, 1'b0, 1'b0, e + 20));
    exp_q.push_back(ev(1, 1'b0, 1'b1, e + 20));
    exp_q.push_back(ev(0, 1'b0, 1'b1, e + 30));
    exp_q.push_back(ev(0, 1'b0, 1'b0, r));
    exp_q.push_back(ev(1, 1'b0, 1'b0, r));
    exp_q.push_back(ev(0, 1'b0, 1'b1, r + 11));
    exp_q.push_back(ev(0, 1'b0, 1'b0, r + 21));
    exp_q.push_back(ev(1, 1'b0, 1'b1, r + 21));
    wait_neg(r - 1 - cyc);
    rst = 1'b1;
    wait_neg(1);
    checks++;
    if (bus.o_led !== 4'h0 || bus.o_done !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: led=%b done=%b, required led=0000 done=0000",
               bus.o_led, bus.o_done);
    end
    rst = 1'b0;
    wait_neg(r + 25 - cyc);
    mon_mask = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_rates();
    test_rate_change();
    test_burst();
    test_burst_abort();
    test_mode_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
